frame_receiver_with_padding: RTL

Receive side of the padded-frame byte link. Consumes the serial byte stream from frame_generator_with_padding and locates SOF. Captures 16 payload bytes, checks the zero padding and the EOF marker, then presents the payload in parallel with a one-cycle frame_ready pulse. Malformed frames are discarded and flagged with frame_error and a cause code.

---
 rtl/frame_pkg.sv | 26 ++
 rtl/frame_receiver_with_padding_if.sv | 17 +
 rtl/frame_receiver_with_padding.sv | 125 ++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared constants, FSM states and error codes for the padded-frame
// byte link (generator and receiver).
package frame_pkg;

  localparam int PAYLOAD_LEN    = 16;
  localparam int MIN_FRAME_SIZE = 64;

  localparam logic [7:0] SOF_BYTE = 8'h7E;
  localparam logic [7:0] EOF_BYTE = 8'h7F;

  localparam int PAD_LEN =
    (MIN_FRAME_SIZE > PAYLOAD_LEN + 2) ?
    MIN_FRAME_SIZE - PAYLOAD_LEN - 2 : 0;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PAD,
    EOF_CHK
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_PAD  = 2'b01;
  localparam logic [1:0] ERR_EOF  = 2'b10;

endpackage

// File: rtl/frame_receiver_with_padding_if.sv
// Serial byte stream with a per-byte valid qualifier.
interface frame_receiver_with_padding_if;

  logic [7:0] frame_data;
  logic       valid;

  modport master (
    output frame_data,
    output valid
  );

  modport slave (
    input frame_data,
    input valid
  );

endinterface

// File: rtl/frame_receiver_with_padding.sv
// Padded-frame receiver: finds SOF, captures the payload, checks the
// zero padding and EOF, then publishes the payload on a good frame.
module frame_receiver_with_padding
  import frame_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  frame_receiver_with_padding_if.slave rx,
  output logic [7:0]  frame_data_out0,
  output logic [7:0]  frame_data_out1,
  output logic [7:0]  frame_data_out2,
  output logic [7:0]  frame_data_out3,
  output logic [7:0]  frame_data_out4,
  output logic [7:0]  frame_data_out5,
  output logic [7:0]  frame_data_out6,
  output logic [7:0]  frame_data_out7,
  output logic [7:0]  frame_data_out8,
  output logic [7:0]  frame_data_out9,
  output logic [7:0]  frame_data_out10,
  output logic [7:0]  frame_data_out11,
  output logic [7:0]  frame_data_out12,
  output logic [7:0]  frame_data_out13,
  output logic [7:0]  frame_data_out14,
  output logic [7:0]  frame_data_out15,
  output logic        frame_ready,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic        busy,
  output logic [15:0] good_frame_count
);

  localparam logic [6:0] LAST_PAY = 7'(PAYLOAD_LEN - 1);
  localparam logic [6:0] LAST_PAD = 7'(PAD_LEN - 1);

  state_t     state;
  logic [6:0] cnt;
  logic [7:0] shadow [PAYLOAD_LEN];
  logic [7:0] dout   [PAYLOAD_LEN];

  assign busy = (state != IDLE);

  assign frame_data_out0  = dout[0];
  assign frame_data_out1  = dout[1];
  assign frame_data_out2  = dout[2];
  assign frame_data_out3  = dout[3];
  assign frame_data_out4  = dout[4];
  assign frame_data_out5  = dout[5];
  assign frame_data_out6  = dout[6];
  assign frame_data_out7  = dout[7];
  assign frame_data_out8  = dout[8];
  assign frame_data_out9  = dout[9];
  assign frame_data_out10 = dout[10];
  assign frame_data_out11 = dout[11];
  assign frame_data_out12 = dout[12];
  assign frame_data_out13 = dout[13];
  assign frame_data_out14 = dout[14];
  assign frame_data_out15 = dout[15];

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      frame_ready      <= 1'b0;
      frame_error      <= 1'b0;
      error_code       <= ERR_NONE;
      good_frame_count <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        shadow[i] <= '0;
        dout[i]   <= '0;
      end
    end else begin
      frame_ready <= 1'b0;
      frame_error <= 1'b0;
      error_code  <= ERR_NONE;
      if (rx.valid) begin
        unique case (state)
          IDLE: begin
            if (rx.frame_data == SOF_BYTE) begin
              state <= PAYLOAD;
              cnt   <= '0;
            end
          end
          PAYLOAD: begin
            shadow[cnt[3:0]] <= rx.frame_data;
            if (cnt == LAST_PAY) begin
              cnt <= '0;
              if (PAD_LEN > 0) state <= PAD;
              else             state <= EOF_CHK;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          PAD: begin
            // the offending byte is consumed, never re-read as SOF
            if (rx.frame_data != 8'h00) begin
              frame_error <= 1'b1;
              error_code  <= ERR_PAD;
              state       <= IDLE;
            end else if (cnt == LAST_PAD) begin
              cnt   <= '0;
              state <= EOF_CHK;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          EOF_CHK: begin
            state <= IDLE;
            if (rx.frame_data == EOF_BYTE) begin
              frame_ready <= 1'b1;
              for (int i = 0; i < PAYLOAD_LEN; i++)
                dout[i] <= shadow[i];
              if (good_frame_count != 16'hFFFF)
                good_frame_count <= good_frame_count + 16'd1;
            end else begin
              frame_error <= 1'b1;
              error_code  <= ERR_EOF;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
